float_frame_accum: RTL and testbench
====================================

FLOAT_FRAME_ACCUM -- requirements
Module: float_frame_accum

Interface
REQ-001 Parameter FRAME_LEN, default 8, SHALL set the number of samples per frame (legal range 1..255).
REQ-002 Parameter SUM_W, default 16, SHALL set the accumulator and output width (legal range 11..32).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that the upstream int-to-float stage presents a sample.
REQ-006 in_m  input  4  SHALL carry the sample mantissa M[3:0].
REQ-007 in_e  input  3  SHALL carry the sample exponent E[2:0].
REQ-008 in_ready  output  1  SHALL indicate that the block accepts a sample this cycle.
REQ-009 flush  input  1  SHALL be a single-cycle request to close the current frame early.
REQ-010 out_valid  output  1  SHALL indicate that a frame result is presented.
REQ-011 out_ready  input  1  SHALL indicate that the downstream stage consumes the result.
REQ-012 out_sum  output  SUM_W  SHALL be the frame sum, saturated.
REQ-013 out_count  output  8  SHALL be the number of samples in the frame.
REQ-014 out_sat  output  1  SHALL be set if saturation occurred anywhere in the frame.

Function
REQ-015 Each sample SHALL expand to an 11-bit value, value = in_m << in_e, giving a range of 0..1920; E=0 SHALL yield M unchanged.
REQ-016 A sample SHALL be accepted on a cycle where in_valid=1 and in_ready=1.
REQ-017 The FSM SHALL have two states, ACCUM and HOLD. ACCUM: in_ready=1, out_valid=0. HOLD: in_ready=0, out_valid=1.
REQ-018 On each accept, sum SHALL become min(sum+value, 2^SUM_W-1), count SHALL increment, and sat SHALL be set if the clamp is applied.
REQ-019 An accept that makes count equal FRAME_LEN SHALL move the FSM to HOLD on the same edge. out_sum, out_count and out_sat SHALL be valid on the following cycle, giving a latency of 1 cycle from the last accept.
REQ-020 flush in ACCUM with count>0 SHALL move the FSM to HOLD. A sample accepted in the same cycle SHALL be included in the closed frame.
REQ-021 flush with count=0 and no accepted sample SHALL be ignored. flush in HOLD SHALL be ignored.
REQ-022 In HOLD, outputs SHALL remain stable while out_ready=0.
REQ-023 On out_valid and out_ready both high, the FSM SHALL return to ACCUM, and sum, count and sat SHALL clear on that edge.
REQ-024 No sample SHALL be accepted in HOLD. There SHALL be no combinational path from in_valid to in_ready or from out_ready to out_valid.
REQ-025 in_m and in_e SHALL be ignored when in_valid=0.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force the FSM to ACCUM, in_ready=1 after release, out_valid=0, and out_sum, out_count and out_sat to 0. This SHALL hold regardless of state.
REQ-027 Reset mid-frame or mid-HOLD SHALL discard partial or pending results without emitting them.

Structure
REQ-028 A shared package int2float_pkg SHALL hold M_W=4, E_W=3, VAL_W=11, the FSM state enum, and the saturation-add helper.
REQ-029 A combinational sub-module fp_expand SHALL implement REQ-015. It SHALL be reused by any other consumer of the int-to-float codes.

Verification
REQ-030 Reset: assert rst_n=0 after 3 accepts -> out_valid=0, out_sum=0, and the next frame sums from 0.
REQ-031 Full frame: 8 samples of M=15,E=7 with out_ready=1 -> out_sum=15360, out_count=8, out_sat=0, and out_valid asserted 1 cycle after the 8th accept.
REQ-032 Saturation: SUM_W=12, 8 samples of M=15,E=7 -> out_sum=4095, out_sat=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> out_valid=1 and out_sum stable, in_ready=0, and no samples lost once the FSM returns to ACCUM.
REQ-034 Early flush: 3 samples of M=9,E=0, then flush in the same cycle as M=8,E=1 -> out_sum=43, out_count=4.
REQ-035 Idle flush: flush with count=0 -> no out_valid; the next sample M=5,E=0 starts a frame whose sum is 5.

Source files
------------

// File: rtl/int2float_pkg.sv
// Shared definitions for the int-to-float code consumers: field widths,
// frame FSM state encoding and a saturating accumulate helper.
package int2float_pkg;

    localparam int M_W   = 4;
    localparam int E_W   = 3;
    localparam int VAL_W = 11;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] sum;
        logic        sat;
    } sat_sum_t;

    // Adds an expanded sample to a running sum, clamping at max_val.
    function automatic sat_sum_t sat_add(
        input logic [31:0]      acc,
        input logic [VAL_W-1:0] value,
        input logic [31:0]      max_val
    );
        logic [32:0] full;
        sat_sum_t    r;
        full = {1'b0, acc} + {22'b0, value};
        if (full > {1'b0, max_val}) begin
            r.sum = max_val;
            r.sat = 1'b1;
        end else begin
            r.sum = full[31:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_expand.sv
// Expands a mantissa/exponent code into its integer value, value = m << e.
// Purely combinational so any consumer of the codes can reuse it.
module fp_expand
    import int2float_pkg::*;
(
    input  logic [M_W-1:0]   m,
    input  logic [E_W-1:0]   e,
    output logic [VAL_W-1:0] value
);

    assign value = VAL_W'(m) << e;

endmodule

// File: rtl/float_frame_accum.sv
// Accumulates expanded int-to-float samples into saturated frame sums and
// holds each closed frame until the downstream stage takes it.
module float_frame_accum
    import int2float_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [M_W-1:0]   in_m,
    input  logic [E_W-1:0]   in_e,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_sat
);

    localparam logic [31:0] SUM_MAX   = 32'((64'd1 << SUM_W) - 64'd1);
    localparam logic [7:0]  FRAME_CNT = 8'(FRAME_LEN);

    state_t           state, state_nxt;
    logic [SUM_W-1:0] sum_q, sum_nxt;
    logic [7:0]       count_q, count_nxt;
    logic             sat_q, sat_nxt;

    logic [VAL_W-1:0] value;
    logic             accept;
    sat_sum_t         add_r;
    logic             sum_unused;

    fp_expand u_expand (
        .m     (in_m),
        .e     (in_e),
        .value (value)
    );

    // Handshakes depend only on registered state, never on in_valid/out_ready.
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;

    assign add_r      = sat_add(32'(sum_q), value, SUM_MAX);
    assign sum_unused = &{1'b0, add_r.sum};

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        sum_nxt   = sum_q;
        count_nxt = count_q;
        sat_nxt   = sat_q;
        unique case (state)
            ST_ACCUM: begin
                if (accept) begin
                    sum_nxt   = add_r.sum[SUM_W-1:0];
                    count_nxt = count_q + 8'd1;
                    sat_nxt   = sat_q | add_r.sat;
                end
                // An idle flush (nothing held, nothing arriving) is dropped.
                if ((accept && count_nxt == FRAME_CNT) ||
                    (flush && (count_q != 8'd0 || accept))) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = ST_ACCUM;
                    sum_nxt   = '0;
                    count_nxt = 8'd0;
                    sat_nxt   = 1'b0;
                end
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their next values from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ACCUM;
            sum_q   <= '0;
            count_q <= 8'd0;
            sat_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            sum_q   <= sum_nxt;
            count_q <= count_nxt;
            sat_q   <= sat_nxt;
        end
    end

    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_float_frame_accum.sv
// Directed self-checking bench: a default instance plus a SUM_W=12 instance
// sharing the same stimulus, so the narrow one exercises saturation.
module tb_float_frame_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_m = 4'd0;
    logic [2:0]  in_e = 3'd0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_sat;
    logic [15:0] out_sum;
    logic [7:0]  out_count;

    logic        s_in_ready, s_out_valid, s_out_sat;
    logic [11:0] s_out_sum;
    logic [7:0]  s_out_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    float_frame_accum #(.FRAME_LEN(8), .SUM_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_m      (in_m),
        .in_e      (in_e),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    float_frame_accum #(.FRAME_LEN(8), .SUM_W(12)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_m      (in_m),
        .in_e      (in_e),
        .in_ready  (s_in_ready),
        .flush     (flush),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_sum   (s_out_sum),
        .out_count (s_out_count),
        .out_sat   (s_out_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] m, input logic [2:0] e, input logic f);
        in_valid = v;
        in_m     = m;
        in_e     = e;
        flush    = f;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_sum", 32'(out_sum), 0);
        check("rst_count", 32'(out_count), 0);
        check("rst_sat", 32'(out_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Full frame: 8 x (15<<7)=1920 -> 15360; narrow instance clamps at 4095
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'd15, 3'd7, 1'b0);
            step();
            if (i == 6) check("full_no_early_valid", 32'(out_valid), 0);
        end
        drive(1'b0, 4'd0, 3'd0, 1'b0);
        check("full_valid", 32'(out_valid), 1);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_sum", 32'(out_sum), 15360);
        check("full_count", 32'(out_count), 8);
        check("full_sat", 32'(out_sat), 0);
        check("sat_sum", 32'(s_out_sum), 4095);
        check("sat_flag", 32'(s_out_sat), 1);
        check("sat_valid", 32'(s_out_valid), 1);
        step();
        check("full_pop_valid", 32'(out_valid), 0);
        check("full_pop_sum", 32'(out_sum), 0);
        check("sat_pop_flag", 32'(s_out_sat), 0);

        // Backpressure: frame of 8 x 1 held while upstream keeps presenting 2
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'd1, 3'd0, 1'b0);
            step();
        end
        drive(1'b1, 4'd2, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            step();
            check("bp_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_sum", 32'(out_sum), 8);
            check("bp_count", 32'(out_count), 8);
        end
        flush = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(out_valid), 0);
        check("bp_release_ready", 32'(in_ready), 1);
        check("bp_release_count", 32'(out_count), 0);
        step();
        check("bp_resent_count", 32'(out_count), 1);
        check("bp_resent_sum", 32'(out_sum), 2);
        drive(1'b0, 4'd0, 3'd0, 1'b1);
        step();
        flush = 1'b0;
        check("bp_flush_valid", 32'(out_valid), 1);
        check("bp_flush_sum", 32'(out_sum), 2);
        step();

        // Early flush: 9+9+9 then (8<<1) with flush in the same cycle -> 43
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd9, 3'd0, 1'b0);
            step();
        end
        drive(1'b1, 4'd8, 3'd1, 1'b1);
        step();
        drive(1'b0, 4'd0, 3'd0, 1'b0);
        check("ef_valid", 32'(out_valid), 1);
        check("ef_sum", 32'(out_sum), 43);
        check("ef_count", 32'(out_count), 4);
        step();

        // Idle flush ignored; next frame is 5 + (0<<7) = 5
        drive(1'b0, 4'd7, 3'd3, 1'b1);
        step();
        check("if_valid", 32'(out_valid), 0);
        check("if_count", 32'(out_count), 0);
        drive(1'b1, 4'd5, 3'd0, 1'b0);
        step();
        check("if_sum1", 32'(out_sum), 5);
        drive(1'b1, 4'd0, 3'd7, 1'b0);
        step();
        drive(1'b0, 4'd15, 3'd7, 1'b1);
        step();
        flush = 1'b0;
        check("if_close_valid", 32'(out_valid), 1);
        check("if_close_sum", 32'(out_sum), 5);
        check("if_close_count", 32'(out_count), 2);
        step();

        // Reset mid-frame after 3 x (3<<2)=12
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd3, 3'd2, 1'b0);
            step();
        end
        drive(1'b0, 4'd0, 3'd0, 1'b0);
        check("mr_pre_sum", 32'(out_sum), 36);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 0);
        check("mr_sum", 32'(out_sum), 0);
        check("mr_count", 32'(out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'd1, 3'd1, 1'b0);
            step();
        end
        drive(1'b0, 4'd0, 3'd0, 1'b0);
        check("mr_next_sum", 32'(out_sum), 16);
        check("mr_next_valid", 32'(out_valid), 1);

        // Reset mid-HOLD discards the pending frame
        out_ready = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("mh_valid", 32'(out_valid), 0);
        check("mh_sum", 32'(out_sum), 0);
        check("mh_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mh_after_valid", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
